stitch_pipeline_valid_ctrl: RTL and testbench
=============================================

Name: stitch_pipeline_valid_ctrl

Overview:
Valid/ready flow controller for a stitched multi-stage pipeline: per-stage `*_cycleN` combinational modules separated by plain data register banks `p1..pN`.
- Tracks one valid bit per register bank.
- Generates per-bank load enables.
- Propagates downstream backpressure with bubble collapsing.
- Supports a synchronous flush.

The data registers stay enable-gated flops in the stitched wrapper; this block owns only control state.

Parameters:
- NUM_STAGES, 2, number of pipeline register banks (p1..pN); must be >= 1.
- CNT_WIDTH, 32, width of the performance counters (optional feature only).

Ports:
- clk  input  1  clock; all state updates on posedge.
- rst  input  1  synchronous, active-high reset.
- in_valid  input  1  upstream offers an input transaction.
- in_ready  output  1  upstream transaction accepted this cycle when in_valid && in_ready.
- out_valid  output  1  final bank pN holds valid result.
- out_ready  input  1  downstream accepts the result.
- flush  input  1  discard all in-flight transactions.
- stage_en  output  NUM_STAGES  stage_en[i] = load enable for bank p(i+1).
- stage_valid  output  NUM_STAGES  registered valid bit of bank p(i+1).
- occupancy  output  $clog2(NUM_STAGES+1)  count of set stage_valid bits.
- idle  output  1  occupancy == 0.

Behaviour:
- Reset state: all v[i] = 0, so the outputs are:
  - stage_valid = 0, out_valid = 0, occupancy = 0, idle = 1.
  - in_ready = 1 during reset only if rst is not asserted; in_ready and stage_en are forced to 0 while rst = 1.
- Notation: v[i] = stage_valid[i]. up_v[0] = in_valid; up_v[i] = v[i-1] for i > 0.
- Ready chain (combinational, no registered skid):
  - rdy[N-1] = out_ready || !v[N-1].
  - rdy[i] = rdy[i+1] || !v[i].
  - A bubble anywhere downstream lets every stage above it advance in the same cycle.
- in_ready = rdy[0] && !flush && !rst.
- stage_en[i] = rdy[i] && up_v[i] && !flush && !rst.
  - Enable only on valid data; gated for power.
  - No combinational path from in_valid to in_ready.
- Next state (no flush):
  - If rdy[i], then v[i] <= up_v[i].
  - Otherwise v[i] holds.
- out_valid = v[N-1]. Output transfer occurs when out_valid && out_ready.
- Latency: N cycles from input acceptance to out_valid with no backpressure. Throughput is 1 per cycle.
- Stall: with out_ready = 0 and all banks full, in_ready = 0 and all stage_en = 0. Data is held; out_valid stays asserted and stable.
- Flush: has priority over advance.
  - In the flush cycle: in_ready = 0, stage_en = 0, and a concurrent out handshake is still counted as delivered if out_ready = 1.
  - Next cycle: all v = 0.
- Simultaneous out transfer and input acceptance with a full pipe: accepted; occupancy unchanged.
- rst mid-operation: the next cycle has all v = 0; in-flight data is dropped with no output.
- occupancy is a popcount of v, computed combinationally from registers.

Optional Feature:
Macro STITCH_PIPELINE_PERF_CNT_EN.
- When defined, three extra output ports are added, all CNT_WIDTH wide, all reset to 0:
  - xfer_count: counts out handshakes.
  - stall_count: counts cycles with out_valid && !out_ready.
  - flush_count: counts flush cycles with occupancy != 0.
- All counters saturate at all-ones and do not wrap.
- When not defined, these ports and their logic do not exist; the base behaviour is identical either way.

Decomposition:
- Package stitch_pipeline_ctrl_pkg holds:
  - function occ_width(n) = $clog2(n+1).
  - typedef of the perf counter struct {xfer, stall, flush}.
  - constant PERF_CNT_MAX.
- One sub-module, stitch_pipeline_perf_cnt: a saturating counter with a single increment input and a sync reset, instantiated three times under the macro.
- The ready chain and valid registers stay in the top level.

Test Plan (NUM_STAGES = 2 unless stated):
- Reset then idle, with rst held 3 cycles → stage_valid = 2'b00, idle = 1, out_valid = 0, stage_en = 0 while rst = 1; in_ready = 1 in the first cycle after rst drops.
- Single transaction: in_valid pulse at cycle 0 with out_ready = 1 → stage_en = 01 at cycle 0, stage_en = 10 at cycle 1, out_valid = 1 at cycle 2 only, occupancy sequence 1, 1, 0.
- Backpressure: stream 4 back-to-back inputs with out_ready = 0 → in_ready drops after 2 accepts, occupancy = 2, out_valid held; raising out_ready drains 1 per cycle, and all 4 arrive in order.
- Bubble collapse: v = 10, out_ready = 0, in_valid = 1 → in_ready = 1, stage_en = 01, next v = 11.
- Flush with full pipe and out_ready = 1 → that cycle's output is counted, and in_ready = 0; next cycle v = 00, idle = 1.
- Under STITCH_PIPELINE_PERF_CNT_EN with CNT_WIDTH = 4: hold a stall for 20 cycles → stall_count saturates at 15; after 5 transfers, xfer_count = 5.

Source files
------------

// File: rtl/stitch_pipeline_ctrl_pkg.sv
// rtl/stitch_pipeline_ctrl_pkg.sv - shared types and helpers for the stitched pipeline valid controller
// Purpose: occupancy width helper, perf-counter increment struct, and the
//          saturation ceiling used by the optional performance counters.
// Optional feature macro: STITCH_PIPELINE_PERF_CNT_EN (consumers only).
package stitch_pipeline_ctrl_pkg;

  // Widest counter supported; narrower counters slice the low bits.
  localparam int unsigned PERF_CNT_MAX_W = 32;
  localparam logic [PERF_CNT_MAX_W-1:0] PERF_CNT_MAX = '1;

  // One increment strobe per performance counter.
  typedef struct packed {
    logic xfer;
    logic stall;
    logic flush;
  } perf_inc_t;

  // Bits needed to hold a count of 0..n set valid bits.
  function automatic int unsigned occ_width(input int unsigned n);
    return $clog2(n + 1);
  endfunction

endpackage

// File: rtl/stitch_pipeline_perf_cnt.sv
// rtl/stitch_pipeline_perf_cnt.sv - saturating event counter with sync reset
// Purpose: counts cycles where i_inc is high; sticks at all-ones.
// Ports:
//   clk     in   clock
//   rst     in   synchronous active-high reset, clears the count
//   i_inc   in   increment strobe
//   o_count out  current count (WIDTH bits, WIDTH <= 32)
// Optional feature macro: STITCH_PIPELINE_PERF_CNT_EN (instantiated only when defined).
module stitch_pipeline_perf_cnt
  import stitch_pipeline_ctrl_pkg::*;
#(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_inc,
  output logic [WIDTH-1:0] o_count
);

  localparam logic [WIDTH-1:0] CNT_MAX = PERF_CNT_MAX[WIDTH-1:0];

  logic [WIDTH-1:0] r_count;
  logic             w_sat;

  assign w_sat = (r_count == CNT_MAX);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_count <= '0;
    end else if (i_inc && !w_sat) begin
      r_count <= r_count + 1'b1;
    end
  end

  assign o_count = r_count;

endmodule

// File: rtl/stitch_pipeline_valid_ctrl.sv
// rtl/stitch_pipeline_valid_ctrl.sv - valid/ready flow control for a stitched register-bank pipeline
// Purpose: owns one valid bit per data bank p1..pN, drives the bank load
//          enables, collapses bubbles under backpressure and supports a
//          synchronous flush. Data flops live in the stitched wrapper.
// Ports:
//   clk          in   clock
//   rst          in   synchronous active-high reset
//   in_valid     in   upstream offers a transaction
//   in_ready     out  upstream transaction accepted when in_valid && in_ready
//   out_valid    out  bank pN holds a valid result
//   out_ready    in   downstream accepts the result
//   flush        in   drop all in-flight transactions
//   stage_en     out  [NUM_STAGES] load enable for bank p(i+1)
//   stage_valid  out  [NUM_STAGES] valid bit of bank p(i+1)
//   occupancy    out  number of valid banks
//   idle         out  occupancy == 0
//   xfer_count   out  [CNT_WIDTH] out handshakes        (macro only)
//   stall_count  out  [CNT_WIDTH] out_valid && !out_ready (macro only)
//   flush_count  out  [CNT_WIDTH] flushes of a non-empty pipe (macro only)
// Optional feature macro: STITCH_PIPELINE_PERF_CNT_EN
module stitch_pipeline_valid_ctrl
  import stitch_pipeline_ctrl_pkg::*;
#(
  parameter int unsigned NUM_STAGES = 2,
  parameter int unsigned CNT_WIDTH  = 32
) (
  input  logic                                  clk,
  input  logic                                  rst,
  input  logic                                  in_valid,
  output logic                                  in_ready,
  output logic                                  out_valid,
  input  logic                                  out_ready,
  input  logic                                  flush,
  output logic [NUM_STAGES-1:0]                 stage_en,
  output logic [NUM_STAGES-1:0]                 stage_valid,
  output logic [occ_width(NUM_STAGES)-1:0]      occupancy,
  output logic                                  idle
`ifdef STITCH_PIPELINE_PERF_CNT_EN
  ,
  output logic [CNT_WIDTH-1:0]                  xfer_count,
  output logic [CNT_WIDTH-1:0]                  stall_count,
  output logic [CNT_WIDTH-1:0]                  flush_count
`endif
);

  localparam int unsigned OCC_W = occ_width(NUM_STAGES);

  if (NUM_STAGES < 1 || CNT_WIDTH < 1 || CNT_WIDTH > PERF_CNT_MAX_W) begin : g_param_err
    $error("stitch_pipeline_valid_ctrl: NUM_STAGES must be >= 1 and CNT_WIDTH in 1..32");
  end

  logic [NUM_STAGES-1:0] r_v;
  logic [NUM_STAGES-1:0] w_rdy;
  logic [NUM_STAGES-1:0] w_up_v;
  logic [OCC_W-1:0]      w_occ;
  logic                  w_go;

  // Flush and reset both freeze all loads and refuse new input.
  assign w_go = !flush && !rst;

  // Upstream valid seen by each bank: input for p1, previous bank otherwise.
  always_comb begin
    w_up_v    = '0;
    w_up_v[0] = in_valid;
    for (int i = 1; i < NUM_STAGES; i++) begin
      w_up_v[i] = r_v[i-1];
    end
  end

  // Ready ripples upward from the output: any empty bank below lets every
  // bank above it move in the same cycle. Depends only on registered valids
  // and out_ready, so in_valid never reaches in_ready.
  always_comb begin
    logic l_rdy;
    w_rdy = '0;
    l_rdy = out_ready || !r_v[NUM_STAGES-1];
    w_rdy[NUM_STAGES-1] = l_rdy;
    for (int i = NUM_STAGES - 2; i >= 0; i--) begin
      l_rdy    = l_rdy || !r_v[i];
      w_rdy[i] = l_rdy;
    end
  end

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      r_v <= '0;
    end else begin
      for (int i = 0; i < NUM_STAGES; i++) begin
        if (w_rdy[i]) begin
          r_v[i] <= w_up_v[i];
        end
      end
    end
  end

  always_comb begin
    w_occ = '0;
    for (int i = 0; i < NUM_STAGES; i++) begin
      w_occ = w_occ + OCC_W'(r_v[i]);
    end
  end

  // Only load a bank when real data arrives, so empty slots don't toggle flops.
  assign stage_en    = w_rdy & w_up_v & {NUM_STAGES{w_go}};
  assign in_ready    = w_rdy[0] && w_go;
  assign out_valid   = r_v[NUM_STAGES-1];
  assign stage_valid = r_v;
  assign occupancy   = w_occ;
  assign idle        = (w_occ == '0);

`ifdef STITCH_PIPELINE_PERF_CNT_EN
  perf_inc_t w_inc;

  // A flush-cycle handshake still delivers, so xfer ignores flush.
  assign w_inc.xfer  = out_valid && out_ready;
  assign w_inc.stall = out_valid && !out_ready;
  assign w_inc.flush = flush && (w_occ != '0);

  stitch_pipeline_perf_cnt #(.WIDTH(CNT_WIDTH)) u_xfer_cnt (
    .clk     (clk),
    .rst     (rst),
    .i_inc   (w_inc.xfer),
    .o_count (xfer_count)
  );

  stitch_pipeline_perf_cnt #(.WIDTH(CNT_WIDTH)) u_stall_cnt (
    .clk     (clk),
    .rst     (rst),
    .i_inc   (w_inc.stall),
    .o_count (stall_count)
  );

  stitch_pipeline_perf_cnt #(.WIDTH(CNT_WIDTH)) u_flush_cnt (
    .clk     (clk),
    .rst     (rst),
    .i_inc   (w_inc.flush),
    .o_count (flush_count)
  );
`endif

endmodule

// File: tb/tb_stitch_pipeline_valid_ctrl.sv
// tb/tb_stitch_pipeline_valid_ctrl.sv - scoreboard bench for stitch_pipeline_valid_ctrl
module tb_stitch_pipeline_valid_ctrl;

  localparam int NS = 2;
  localparam int CW = 4;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic          out_valid;
  logic          out_ready = 1'b0;
  logic          flush = 1'b0;
  logic [NS-1:0] stage_en;
  logic [NS-1:0] stage_valid;
  logic [1:0]    occupancy;
  logic          idle;
`ifdef STITCH_PIPELINE_PERF_CNT_EN
  logic [CW-1:0] xfer_count;
  logic [CW-1:0] stall_count;
  logic [CW-1:0] flush_count;
`endif

  logic [7:0] in_data = 8'h00;
  logic [7:0] bank [NS];
  logic [7:0] exp_q [$];
  int n_checks = 0;
  int n_err    = 0;
  int n_deliv  = 0;

  always #5 clk = ~clk;

  stitch_pipeline_valid_ctrl #(.NUM_STAGES(NS), .CNT_WIDTH(CW)) dut (
    .clk         (clk),
    .rst         (rst),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .flush       (flush),
    .stage_en    (stage_en),
    .stage_valid (stage_valid),
    .occupancy   (occupancy),
    .idle        (idle)
`ifdef STITCH_PIPELINE_PERF_CNT_EN
    ,
    .xfer_count  (xfer_count),
    .stall_count (stall_count),
    .flush_count (flush_count)
`endif
  );

  // Stitched-wrapper data banks, loaded only by the DUT enables.
  always @(posedge clk) begin
    if (stage_en[0]) bank[0] <= in_data;
    for (int i = 1; i < NS; i++) begin
      if (stage_en[i]) bank[i] <= bank[i-1];
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Monitor: every out handshake must deliver the oldest expected tag.
  always @(negedge clk) begin
    if (out_valid && out_ready) begin
      n_deliv++;
      if (exp_q.size() == 0) begin
        n_checks++;
        n_err++;
        $display("FAIL out_unexpected: got %0h expected none", bank[NS-1]);
      end else begin
        chk("out_data", {24'h0, bank[NS-1]}, {24'h0, exp_q.pop_front()});
      end
    end
    if (flush || rst) exp_q.delete();
  end

  // One cycle: drive after the edge, sample at the falling edge, record acceptance.
  task automatic cyc(input logic iv, input logic [7:0] d, input logic ordy,
                     input logic fl, input logic rs);
    @(posedge clk);
    #1;
    in_valid  = iv;
    in_data   = d;
    out_ready = ordy;
    flush     = fl;
    rst       = rs;
    @(negedge clk);
    if (in_valid && in_ready) exp_q.push_back(in_data);
  endtask

  initial begin
    #100000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end

  initial begin
    // Reset held 3 cycles with in_valid high: everything gated.
    for (int k = 0; k < 3; k++) begin
      cyc(1'b1, 8'h00, 1'b1, 1'b0, 1'b1);
      chk("rst_stage_valid", 32'(stage_valid), 32'h0);
      chk("rst_idle", 32'(idle), 32'h1);
      chk("rst_out_valid", 32'(out_valid), 32'h0);
      chk("rst_stage_en", 32'(stage_en), 32'h0);
      chk("rst_in_ready", 32'(in_ready), 32'h0);
    end
    cyc(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
    chk("post_rst_in_ready", 32'(in_ready), 32'h1);
    chk("post_rst_occ", 32'(occupancy), 32'h0);

    // Single transaction.
    cyc(1'b1, 8'hA1, 1'b1, 1'b0, 1'b0);
    chk("single_en0", 32'(stage_en), 32'h1);
    cyc(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
    chk("single_en1", 32'(stage_en), 32'h2);
    chk("single_occ1", 32'(occupancy), 32'h1);
    chk("single_ov1", 32'(out_valid), 32'h0);
    cyc(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
    chk("single_ov2", 32'(out_valid), 32'h1);
    chk("single_occ2", 32'(occupancy), 32'h1);
    chk("single_en2", 32'(stage_en), 32'h0);
    cyc(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
    chk("single_ov3", 32'(out_valid), 32'h0);
    chk("single_occ3", 32'(occupancy), 32'h0);
    chk("single_idle3", 32'(idle), 32'h1);

    // Backpressure: 4 inputs, out_ready low then drain.
    cyc(1'b1, 8'hB0, 1'b0, 1'b0, 1'b0);
    chk("bp_rdy0", 32'(in_ready), 32'h1);
    chk("bp_en0", 32'(stage_en), 32'h1);
    cyc(1'b1, 8'hB1, 1'b0, 1'b0, 1'b0);
    chk("bp_rdy1", 32'(in_ready), 32'h1);
    chk("bp_en1", 32'(stage_en), 32'h3);
    for (int k = 0; k < 2; k++) begin
      cyc(1'b1, 8'hB2, 1'b0, 1'b0, 1'b0);
      chk("bp_stall_rdy", 32'(in_ready), 32'h0);
      chk("bp_stall_en", 32'(stage_en), 32'h0);
      chk("bp_stall_occ", 32'(occupancy), 32'h2);
      chk("bp_stall_ov", 32'(out_valid), 32'h1);
    end
    cyc(1'b1, 8'hB2, 1'b1, 1'b0, 1'b0);
    chk("bp_full_xfer_rdy", 32'(in_ready), 32'h1);
    chk("bp_full_xfer_en", 32'(stage_en), 32'h3);
    chk("bp_full_xfer_occ", 32'(occupancy), 32'h2);
    cyc(1'b1, 8'hB3, 1'b1, 1'b0, 1'b0);
    chk("bp_full_xfer_occ2", 32'(occupancy), 32'h2);
    cyc(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
    chk("bp_drain_en", 32'(stage_en), 32'h2);
    cyc(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
    chk("bp_drain_occ", 32'(occupancy), 32'h1);
    chk("bp_drain_sv", 32'(stage_valid), 32'h2);
    cyc(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
    chk("bp_drain_idle", 32'(idle), 32'h1);

    // Bubble collapse: v = 10 with out_ready low.
    cyc(1'b1, 8'hC0, 1'b0, 1'b0, 1'b0);
    cyc(1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
    cyc(1'b1, 8'hC1, 1'b0, 1'b0, 1'b0);
    chk("bub_sv", 32'(stage_valid), 32'h2);
    chk("bub_rdy", 32'(in_ready), 32'h1);
    chk("bub_en", 32'(stage_en), 32'h1);
    cyc(1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
    chk("bub_next_sv", 32'(stage_valid), 32'h3);
    chk("bub_next_rdy", 32'(in_ready), 32'h0);

    // Flush a full pipe while delivering.
    cyc(1'b1, 8'hC2, 1'b1, 1'b1, 1'b0);
    chk("fl_rdy", 32'(in_ready), 32'h0);
    chk("fl_en", 32'(stage_en), 32'h0);
    chk("fl_ov", 32'(out_valid), 32'h1);
    cyc(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
    chk("fl_next_sv", 32'(stage_valid), 32'h0);
    chk("fl_next_idle", 32'(idle), 32'h1);
    chk("fl_next_ov", 32'(out_valid), 32'h0);

    // Reset mid-operation drops in-flight data.
    cyc(1'b1, 8'hD0, 1'b0, 1'b0, 1'b0);
    cyc(1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
    cyc(1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
    chk("rstmid_en", 32'(stage_en), 32'h0);
    cyc(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
    chk("rstmid_sv", 32'(stage_valid), 32'h0);
    chk("rstmid_ov", 32'(out_valid), 32'h0);
    chk("deliveries", 32'(n_deliv), 32'd6);

`ifdef STITCH_PIPELINE_PERF_CNT_EN
    cyc(1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
    cyc(1'b1, 8'hE0, 1'b0, 1'b0, 1'b0);
    chk("perf_rst_xfer", 32'(xfer_count), 32'h0);
    chk("perf_rst_stall", 32'(stall_count), 32'h0);
    chk("perf_rst_flush", 32'(flush_count), 32'h0);
    cyc(1'b1, 8'hE1, 1'b0, 1'b0, 1'b0);
    for (int k = 0; k < 20; k++) cyc(1'b1, 8'hE2, 1'b0, 1'b0, 1'b0);
    chk("perf_stall_sat", 32'(stall_count), 32'd15);
    for (int k = 0; k < 5; k++) cyc(1'b1, 8'hE2 + 8'(k), 1'b1, 1'b0, 1'b0);
    cyc(1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
    chk("perf_xfer5", 32'(xfer_count), 32'd5);
    chk("perf_stall_hold", 32'(stall_count), 32'd15);
    cyc(1'b0, 8'h00, 1'b0, 1'b1, 1'b0);
    cyc(1'b0, 8'h00, 1'b0, 1'b1, 1'b0);
    cyc(1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
    chk("perf_flush1", 32'(flush_count), 32'd1);
`endif

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
